// File: rtl/striping.sv
// rtl/striping.sv - two-lane round-robin striping of one word stream, one FIFO per lane

module striping_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;

    assign valid  = (count != '0);
    assign full   = (count == FULL_CNT);
    assign do_pop = valid && pop_ready;
    assign head   = valid ? mem[rd_ptr] : '0;

    // Storage is not reset; the head is masked by valid so stale entries never show.
    always_ff @(posedge clk_2f) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module striping #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] lane_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic [WIDTH-1:0] lane_1,
    output logic             valid_1,
    input  logic             ready_1
);
    logic sel;
    logic full_0;
    logic full_1;
    logic accept;
    logic push_0;
    logic push_1;

    // Readiness looks only at the stored count, so a pop in the same cycle cannot open a full lane.
    assign ready_in = sel ? !full_1 : !full_0;
    assign accept   = valid_in && ready_in;
    assign push_0   = accept && !sel;
    assign push_1   = accept && sel;

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            sel <= 1'b0;
        end else if (accept) begin
            sel <= !sel;
        end
    end

    striping_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .push      (push_0),
        .push_data (data_in),
        .pop_ready (ready_0),
        .head      (lane_0),
        .valid     (valid_0),
        .full      (full_0)
    );

    striping_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .push      (push_1),
        .push_data (data_in),
        .pop_ready (ready_1),
        .head      (lane_1),
        .valid     (valid_1),
        .full      (full_1)
    );
endmodule

// File: tb/tb_striping.sv
// tb/tb_striping.sv - directed bench for the two-lane striping block

module tb_striping;
    logic        clk_2f = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] lane_0;
    logic        valid_0;
    logic        ready_0 = 1'b0;
    logic [31:0] lane_1;
    logic        valid_1;
    logic        ready_1 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] got0[$];
    logic [31:0] got1[$];
    logic [31:0] exp_q[$];
    logic        acc;
    int          w;

    striping u_dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .ready_0  (ready_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .ready_1  (ready_1)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] q[$], input logic [31:0] e[$]);
        check({tag, "_size"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            check(tag, (i < q.size()) ? q[i] : 32'hxxxx_xxxx, e[i]);
        end
    endtask

    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    // Records pops and acceptance as seen just before the edge, then advances one cycle.
    task automatic tick();
        if (valid_0 && ready_0) got0.push_back(lane_0);
        if (valid_1 && ready_1) got1.push_back(lane_1);
        acc = valid_in && ready_in;
        step();
    endtask

    initial begin
        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            data_in  = $urandom;
            valid_in = 1'($urandom_range(0, 1));
            ready_0  = 1'($urandom_range(0, 1));
            ready_1  = 1'($urandom_range(0, 1));
            step();
            check("rst_valid_0", valid_0, 0);
            check("rst_valid_1", valid_1, 0);
            check("rst_lane_0", lane_0, 0);
            check("rst_lane_1", lane_1, 0);
        end
        valid_in = 1'b0;
        reset = 1'b1;
        step();
        check("rst_ready_in", ready_in, 1);

        // 2: back-to-back with both lanes ready
        ready_0 = 1'b1; ready_1 = 1'b1;
        valid_in = 1'b1; data_in = 32'hFFFF_FFFF;
        step();
        check("t2_lane_0_a", lane_0, 32'hFFFF_FFFF);
        check("t2_valid_1_a", valid_1, 0);
        data_in = 32'hEEEE_EEEE;
        step();
        check("t2_lane_1_a", lane_1, 32'hEEEE_EEEE);
        check("t2_valid_0_b", valid_0, 0);
        data_in = 32'hDDDD_DDDD;
        step();
        check("t2_lane_0_b", lane_0, 32'hDDDD_DDDD);
        check("t2_valid_1_b", valid_1, 0);
        data_in = 32'hCCCC_CCCC;
        step();
        check("t2_lane_1_b", lane_1, 32'hCCCC_CCCC);
        check("t2_valid_0_c", valid_0, 0);
        valid_in = 1'b0;
        step();
        check("t2_empty_0", valid_0, 0);
        check("t2_empty_1", valid_1, 0);

        // 3: lane 1 back-pressured, words 1..12
        got0.delete(); got1.delete();
        ready_0 = 1'b1; ready_1 = 1'b0;
        w = 1;
        for (int i = 0; i < 9; i++) begin
            data_in = 32'(w); valid_in = 1'b1;
            check("t3_ready_in", ready_in, 1);
            tick();
            if (acc) w++;
        end
        data_in = 32'(w);
        check("t3_stall_word", 32'(w), 10);
        check("t3_stall_ready", ready_in, 0);
        check("t3_lane_1_head", lane_1, 2);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_ready", ready_in, 0);
            tick();
        end
        check("t3_lane_0_drained", valid_0, 0);
        ready_1 = 1'b1;
        check("t3_no_passthru", ready_in, 0);
        tick();
        check("t3_resume", ready_in, 1);
        for (int i = 0; i < 40; i++) begin
            data_in  = 32'(w);
            valid_in = (w <= 12);
            if (w > 12 && !valid_0 && !valid_1) break;
            tick();
            if (acc) w++;
        end
        valid_in = 1'b0;
        check("t3_all_accepted", 32'(w), 13);
        exp_q = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11};
        check_q("t3_lane_0_order", got0, exp_q);
        exp_q = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12};
        check_q("t3_lane_1_order", got1, exp_q);

        // 4: idle gap does not skip a lane
        ready_0 = 1'b0; ready_1 = 1'b0;
        data_in = 32'h0000_0003; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("t4_lane_0", lane_0, 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            data_in = $urandom;
            step();
        end
        check("t4_gap_valid_1", valid_1, 0);
        data_in = 32'h0000_0004; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("t4_lane_1", lane_1, 32'h0000_0004);
        check("t4_lane_0_kept", lane_0, 32'h0000_0003);
        ready_0 = 1'b1; ready_1 = 1'b1;
        step();
        check("t4_drained", {valid_0, valid_1}, 0);

        // 5: fill both FIFOs, then interleave pops with pushes
        got0.delete(); got1.delete();
        ready_0 = 1'b0; ready_1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in = 32'h50 + 32'(i); valid_in = 1'b1;
            check("t5_fill_ready", ready_in, 1);
            tick();
        end
        check("t5_full_ready", ready_in, 0);
        check("t5_full_lane_0", lane_0, 32'h50);
        check("t5_full_lane_1", lane_1, 32'h51);
        data_in = 32'h58; ready_0 = 1'b1;
        check("t5_pop_no_passthru", ready_in, 0);
        tick();
        check("t5_after_pop_ready", ready_in, 1);
        check("t5_after_pop_lane_0", lane_0, 32'h52);
        tick();
        check("t5_pushpop_acc", acc, 1);
        check("t5_pushpop_ready", ready_in, 0);
        check("t5_pushpop_lane_0", lane_0, 32'h54);
        ready_0 = 1'b0; ready_1 = 1'b1; data_in = 32'h59;
        tick();
        check("t5_f1_pop_ready", ready_in, 1);
        check("t5_f1_pop_lane_1", lane_1, 32'h53);
        tick();
        check("t5_f1_pushpop_lane_1", lane_1, 32'h55);
        ready_1 = 1'b0; data_in = 32'h5A;
        tick();
        check("t5_f0_refill_ready", ready_in, 1);
        data_in = 32'h5B;
        tick();
        check("t5_both_full_ready", ready_in, 0);
        check("t5_both_full_valid", {valid_0, valid_1}, 2'b11);
        valid_in = 1'b0; ready_0 = 1'b1; ready_1 = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t5_drained", {valid_0, valid_1}, 0);
        exp_q = '{32'h50, 32'h52, 32'h54, 32'h56, 32'h58, 32'h5A};
        check_q("t5_lane_0_order", got0, exp_q);
        exp_q = '{32'h51, 32'h53, 32'h55, 32'h57, 32'h59, 32'h5B};
        check_q("t5_lane_1_order", got1, exp_q);

        // 6: asynchronous reset with three words buffered
        ready_0 = 1'b0; ready_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h61 + 32'(i); valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        check("t6_buffered", {valid_0, valid_1}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", {valid_0, valid_1}, 0);
        check("t6_async_lane_0", lane_0, 0);
        check("t6_async_lane_1", lane_1, 0);
        step();
        reset = 1'b1;
        step();
        check("t6_release_ready", ready_in, 1);
        data_in = 32'hA5A5_A5A5; valid_in = 1'b1;
        step();
        check("t6_first_lane_0", lane_0, 32'hA5A5_A5A5);
        check("t6_first_valid_1", valid_1, 0);
        data_in = 32'h5A5A_5A5A;
        step();
        valid_in = 1'b0;
        check("t6_second_lane_1", lane_1, 32'h5A5A_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
